// File: rtl/tube_par_bus_ctrl.sv
// Parasite-side bus master for the Tube ULA: turns read/write commands into timed
// chip-select/strobe cycles and synchronises the Tube's NMI, IRQ and reset lines.
module tube_par_bus_ctrl #(
    parameter int SETUP_CYC   = 1,
    parameter int STROBE_CYC  = 3,
    parameter int HOLD_CYC    = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_b,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_write,
    input  logic [2:0] cmd_addr,
    input  logic [7:0] cmd_wdata,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_rdata,
    output logic [2:0] p_addr,
    output logic       p_cs_b,
    output logic       p_rd_b,
    output logic       p_wr_b,
    output logic [7:0] p_data_o,
    output logic       p_data_oe,
    input  logic [7:0] p_data_i,
    input  logic       p_nmi_b,
    input  logic       p_irq_b,
    input  logic       tube_rst_b,
    output logic       nmi,
    output logic       irq,
    output logic       par_reset
);

    typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, RESP} state_t;

    localparam logic [3:0] SETUP_RLD  = 4'(SETUP_CYC - 1);
    localparam logic [3:0] STROBE_RLD = 4'(STROBE_CYC - 1);
    localparam logic [3:0] HOLD_RLD   = 4'(HOLD_CYC - 1);

    state_t                 r_state;
    logic [3:0]             r_cnt;
    logic                   r_write;
    logic [SYNC_STAGES-1:0] r_rst_sync;
    logic [SYNC_STAGES-1:0] r_nmi_sync;
    logic [SYNC_STAGES-1:0] r_irq_sync;
    logic                   w_par_reset_nxt;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_rst_sync <= '0;
            r_nmi_sync <= '1;
            r_irq_sync <= '1;
        end else begin
            r_rst_sync <= {r_rst_sync[SYNC_STAGES-2:0], tube_rst_b};
            r_nmi_sync <= {r_nmi_sync[SYNC_STAGES-2:0], p_nmi_b};
            r_irq_sync <= {r_irq_sync[SYNC_STAGES-2:0], p_irq_b};
        end
    end

    assign par_reset = ~r_rst_sync[SYNC_STAGES-1];
    assign nmi       = ~r_nmi_sync[SYNC_STAGES-1];
    assign irq       = ~r_irq_sync[SYNC_STAGES-1];

    // Value par_reset takes after this edge; lets cmd_ready track !par_reset with no lag.
    assign w_par_reset_nxt = ~r_rst_sync[SYNC_STAGES-2];

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_write   <= 1'b0;
            p_addr    <= '0;
            p_cs_b    <= 1'b1;
            p_rd_b    <= 1'b1;
            p_wr_b    <= 1'b1;
            p_data_o  <= '0;
            p_data_oe <= 1'b0;
            cmd_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        r_state   <= SETUP;
                        r_cnt     <= SETUP_RLD;
                        r_write   <= cmd_write;
                        p_addr    <= cmd_addr;
                        p_data_o  <= cmd_write ? cmd_wdata : 8'h00;
                        p_data_oe <= cmd_write;
                        p_cs_b    <= 1'b0;
                        cmd_ready <= 1'b0;
                    end else begin
                        cmd_ready <= ~w_par_reset_nxt;
                    end
                end
                SETUP: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= STROBE;
                        r_cnt   <= STROBE_RLD;
                        p_rd_b  <= r_write;
                        p_wr_b  <= ~r_write;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                STROBE: begin
                    if (r_cnt == 4'd0) begin
                        if (!r_write) begin
                            rsp_rdata <= p_data_i;
                        end
                        r_state <= HOLD;
                        r_cnt   <= HOLD_RLD;
                        p_rd_b  <= 1'b1;
                        p_wr_b  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                HOLD: begin
                    if (r_cnt == 4'd0) begin
                        p_cs_b    <= 1'b1;
                        p_addr    <= '0;
                        p_data_o  <= '0;
                        p_data_oe <= 1'b0;
                        // A read finishing under parasite reset drops its response.
                        if (!r_write && !par_reset) begin
                            r_state   <= RESP;
                            rsp_valid <= 1'b1;
                        end else begin
                            r_state   <= IDLE;
                            cmd_ready <= ~w_par_reset_nxt;
                        end
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (par_reset || rsp_ready) begin
                        rsp_valid <= 1'b0;
                        r_state   <= IDLE;
                        cmd_ready <= ~w_par_reset_nxt;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tube_par_bus_ctrl.sv
// Scoreboard bench for tube_par_bus_ctrl: one instance with default timing and one
// with stretched timing, observed through a selectable monitor.
module tb_tube_par_bus_ctrl;

    localparam int S1 = 1, T1 = 3, H1 = 1;
    localparam int S2 = 2, T2 = 5, H2 = 3;

    logic       clk = 1'b0;
    logic       rst_b;
    logic       cmd_valid, cmd_valid2, cmd_write, rsp_ready;
    logic [2:0] cmd_addr;
    logic [7:0] cmd_wdata, p_data_i;
    logic       p_nmi_b, p_irq_b, tube_rst_b;
    logic       sel;

    logic       d1_cmd_ready, d1_rsp_valid, d1_cs_b, d1_rd_b, d1_wr_b, d1_oe, d1_nmi, d1_irq, d1_par_reset;
    logic [7:0] d1_rsp_rdata, d1_data_o;
    logic [2:0] d1_addr;
    logic       d2_cmd_ready, d2_rsp_valid, d2_cs_b, d2_rd_b, d2_wr_b, d2_oe, d2_nmi, d2_irq, d2_par_reset;
    logic [7:0] d2_rsp_rdata, d2_data_o;
    logic [2:0] d2_addr;

    always #5 clk = ~clk;

    tube_par_bus_ctrl u_dut (
        .clk(clk), .rst_b(rst_b), .cmd_valid(cmd_valid), .cmd_ready(d1_cmd_ready),
        .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(d1_rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(d1_rsp_rdata),
        .p_addr(d1_addr), .p_cs_b(d1_cs_b), .p_rd_b(d1_rd_b), .p_wr_b(d1_wr_b),
        .p_data_o(d1_data_o), .p_data_oe(d1_oe), .p_data_i(p_data_i),
        .p_nmi_b(p_nmi_b), .p_irq_b(p_irq_b), .tube_rst_b(tube_rst_b),
        .nmi(d1_nmi), .irq(d1_irq), .par_reset(d1_par_reset)
    );

    tube_par_bus_ctrl #(.SETUP_CYC(S2), .STROBE_CYC(T2), .HOLD_CYC(H2), .SYNC_STAGES(2)) u_dut2 (
        .clk(clk), .rst_b(rst_b), .cmd_valid(cmd_valid2), .cmd_ready(d2_cmd_ready),
        .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(d2_rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(d2_rsp_rdata),
        .p_addr(d2_addr), .p_cs_b(d2_cs_b), .p_rd_b(d2_rd_b), .p_wr_b(d2_wr_b),
        .p_data_o(d2_data_o), .p_data_oe(d2_oe), .p_data_i(p_data_i),
        .p_nmi_b(p_nmi_b), .p_irq_b(p_irq_b), .tube_rst_b(tube_rst_b),
        .nmi(d2_nmi), .irq(d2_irq), .par_reset(d2_par_reset)
    );

    logic       m_cmd_ready, m_rsp_valid, m_cs_b, m_rd_b, m_wr_b, m_oe, m_nmi, m_irq, m_par_reset;
    logic [7:0] m_rsp_rdata, m_data_o;
    logic [2:0] m_addr;
    assign m_cmd_ready = sel ? d2_cmd_ready : d1_cmd_ready;
    assign m_rsp_valid = sel ? d2_rsp_valid : d1_rsp_valid;
    assign m_rsp_rdata = sel ? d2_rsp_rdata : d1_rsp_rdata;
    assign m_cs_b      = sel ? d2_cs_b      : d1_cs_b;
    assign m_rd_b      = sel ? d2_rd_b      : d1_rd_b;
    assign m_wr_b      = sel ? d2_wr_b      : d1_wr_b;
    assign m_addr      = sel ? d2_addr      : d1_addr;
    assign m_data_o    = sel ? d2_data_o    : d1_data_o;
    assign m_oe        = sel ? d2_oe        : d1_oe;
    assign m_nmi       = sel ? d2_nmi       : d1_nmi;
    assign m_irq       = sel ? d2_irq       : d1_irq;
    assign m_par_reset = sel ? d2_par_reset : d1_par_reset;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int acc_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    typedef struct packed {logic [2:0] a; logic [7:0] d;} wexp_t;
    wexp_t      wq[$];
    logic [7:0] rq[$];

    logic       prev_cs = 1'b1;
    logic       prev_wr = 1'b1;
    logic [2:0] prev_addr = '0;
    logic [7:0] prev_data = '0;

    always @(negedge clk) begin
        if (rst_b === 1'b1) begin
            if (!m_rd_b || !m_wr_b)
                chk("strobe_vs_cs", 32'({~m_rd_b & ~m_wr_b, m_cs_b}), 32'd0);
            if (!m_cs_b && !prev_cs)
                chk("addr_data_stable", 32'({m_addr, m_data_o}), 32'({prev_addr, prev_data}));
            if (m_wr_b && !prev_wr) begin
                if (wq.size() == 0) chk("wq_underflow", 32'd1, 32'd0);
                else begin
                    chk("wr_latch", 32'({m_addr, m_data_o, m_oe}), 32'({wq[0].a, wq[0].d, 1'b1}));
                    wq.delete(0);
                end
            end
            if (m_rsp_valid && rsp_ready) begin
                if (rq.size() == 0) chk("rq_underflow", 32'd1, 32'd0);
                else begin
                    chk("rsp_rdata", 32'(m_rsp_rdata), 32'(rq[0]));
                    rq.delete(0);
                end
            end
        end
        prev_cs   <= m_cs_b;
        prev_wr   <= m_wr_b;
        prev_addr <= m_addr;
        prev_data <= m_data_o;
    end

    // mode 0: traced cycle; 1: traced read with tube_rst_b dropped mid-strobe; 2: no trace
    task automatic do_cmd(input bit wr, input logic [2:0] a, input logic [7:0] d,
                          input bit keep, input int mode);
        int s, t, h, l, n;
        s = sel ? S2 : S1;
        t = sel ? T2 : T1;
        h = sel ? H2 : H1;
        l = s + t + h;
        cmd_write = wr;
        cmd_addr  = a;
        cmd_wdata = wr ? d : 8'h00;
        p_data_i  = ~d;
        if (sel) cmd_valid2 = 1'b1;
        else cmd_valid = 1'b1;
        n = 0;
        while (!m_cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!m_cmd_ready) begin
            chk("accept_timeout", 32'd0, 32'd1);
            cmd_valid  = 1'b0;
            cmd_valid2 = 1'b0;
            return;
        end
        if (mode != 1) begin
            if (wr) wq.push_back('{a: a, d: d});
            else rq.push_back(d);
        end
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        if (!keep) begin
            cmd_valid  = 1'b0;
            cmd_valid2 = 1'b0;
        end
        if (mode == 2) return;
        for (int k = 0; k <= l; k++) begin
            @(negedge clk);
            chk("cs_b", 32'(m_cs_b), (k < l) ? 32'd0 : 32'd1);
            chk("strobe", 32'(wr ? m_wr_b : m_rd_b), (k >= s && k < s + t) ? 32'd0 : 32'd1);
            chk("other_strobe", 32'(wr ? m_rd_b : m_wr_b), 32'd1);
            if (!wr && k == s + t - 1) p_data_i = d;
            if (!wr && k == s + t) p_data_i = ~d;
            if (mode == 1 && k == 1) tube_rst_b = 1'b0;
            if (k == l - 1) chk("done_early", 32'({m_cmd_ready, m_rsp_valid}), 32'd0);
            if (k == l) begin
                if (wr) chk("wr_done_ready", 32'(m_cmd_ready), 32'd1);
                else chk("rd_done_rsp", 32'({m_rsp_valid, m_cmd_ready}), (mode == 1) ? 32'd0 : 32'd2);
            end
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired checks=%0d", n_chk);
        $fatal(1, "watchdog");
    end

    initial begin
        int a1;
        rst_b = 1'b0; sel = 1'b0; cmd_valid = 1'b0; cmd_valid2 = 1'b0; cmd_write = 1'b0;
        cmd_addr = '0; cmd_wdata = '0; rsp_ready = 1'b1; p_data_i = '0;
        p_nmi_b = 1'b1; p_irq_b = 1'b1; tube_rst_b = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_bus", 32'({m_cs_b, m_rd_b, m_wr_b, m_addr, m_data_o, m_oe}), 32'({3'b111, 3'b000, 8'h00, 1'b0}));
        chk("rst_hs", 32'({m_cmd_ready, m_rsp_valid, m_rsp_rdata}), 32'd0);
        chk("rst_sync", 32'({m_nmi, m_irq, m_par_reset}), 32'b001);

        @(posedge clk); #1 rst_b = 1'b1;
        repeat (3) @(negedge clk);
        chk("pr_held", 32'({m_par_reset, m_cmd_ready}), 32'b10);

        // parasite reset release: par_reset falls two edges after tube_rst_b rises
        @(posedge clk); #1 tube_rst_b = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("pr_edge1", 32'({m_par_reset, m_cmd_ready}), 32'b10);
        @(negedge clk);
        chk("pr_edge2", 32'({m_par_reset, m_cmd_ready}), 32'b01);

        do_cmd(1'b1, 3'b001, 8'hA5, 1'b0, 0);

        rsp_ready = 1'b0;
        do_cmd(1'b0, 3'b111, 8'h3C, 1'b0, 0);
        repeat (3) begin
            @(negedge clk);
            chk("rsp_hold", 32'({m_rsp_valid, m_rsp_rdata}), 32'({1'b1, 8'h3C}));
        end
        @(posedge clk); #1 rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rsp_cleared", 32'({m_rsp_valid, m_cmd_ready}), 32'b01);

        do_cmd(1'b1, 3'b010, 8'h5A, 1'b1, 0);
        a1 = acc_cyc;
        do_cmd(1'b0, 3'b100, 8'hC3, 1'b0, 0);
        chk("b2b_gap", 32'(acc_cyc - a1), 32'(S1 + T1 + H1 + 1));

        do_cmd(1'b0, 3'b110, 8'h81, 1'b0, 1);
        repeat (3) begin
            @(negedge clk);
            chk("pr_no_rsp", 32'({m_rsp_valid, m_cmd_ready, m_par_reset}), 32'b001);
        end
        tube_rst_b = 1'b1;
        repeat (3) @(negedge clk);
        chk("pr_recovered", 32'({m_par_reset, m_cmd_ready}), 32'b01);

        sel = 1'b1;
        do_cmd(1'b0, 3'b011, 8'h96, 1'b0, 0);
        do_cmd(1'b1, 3'b110, 8'h69, 1'b0, 0);
        @(negedge clk);
        sel = 1'b0;

        @(posedge clk); #1 p_irq_b = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk);
            #1;
            if (k == 3) p_irq_b = 1'b1;
            @(negedge clk);
            chk("irq", 32'({m_nmi, m_irq}), (k >= 2 && k <= 4) ? 32'd1 : 32'd0);
        end

        do_cmd(1'b1, 3'b101, 8'h3F, 1'b0, 2);
        repeat (S1 + T1 + H1) @(negedge clk);
        chk("in_hold", 32'({m_cs_b, m_wr_b, m_oe}), 32'b011);
        #2 rst_b = 1'b0;
        #1;
        chk("async_rst_bus", 32'({m_cs_b, m_rd_b, m_wr_b, m_addr, m_data_o, m_oe}), 32'({3'b111, 3'b000, 8'h00, 1'b0}));
        chk("async_rst_ctl", 32'({m_cmd_ready, m_rsp_valid, m_par_reset}), 32'b001);
        @(posedge clk); #1 rst_b = 1'b1;

        do_cmd(1'b0, 3'b001, 8'h7E, 1'b0, 0);
        repeat (2) @(negedge clk);
        chk("wq_drained", 32'(wq.size()), 32'd0);
        chk("rq_drained", 32'(rq.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
